// File: rtl/player_ctrl_if.sv
// Fire handshake between player_ctrl and the projectile engine.
// The master drives the shot request; the slave answers with ready/done.
interface player_ctrl_if #(
   parameter int unsigned X_W   = 5,
   parameter int unsigned AIM_W = 3
) ();

   logic             fire_valid;
   logic             fire_ready;
   logic [X_W-1:0]   fire_x;
   logic [AIM_W-1:0] fire_aim;
   logic             shot_done;

   modport master (
      output fire_valid,
      output fire_x,
      output fire_aim,
      input  fire_ready,
      input  shot_done
   );

   modport slave (
      input  fire_valid,
      input  fire_x,
      input  fire_aim,
      output fire_ready,
      output shot_done
   );

endinterface

// File: rtl/player_ctrl.sv
// Turns button action pulses into player column/aim, a new-game handshake
// and a valid/ready fire request with shot count and post-shot cooldown.
module player_ctrl #(
   parameter int unsigned X_W      = 5,
   parameter int unsigned X_MAX    = 23,
   parameter int unsigned X_INIT   = 12,
   parameter int unsigned AIM_W    = 3,
   parameter int unsigned AIM_INIT = 4,
   parameter int unsigned COOLDOWN = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic             left_x,
   input  logic             right_x,
   input  logic             left_aim,
   input  logic             right_aim,
   input  logic             shoot_in,
   input  logic [4:0]       select,
   output logic [X_W-1:0]   player_x,
   output logic [AIM_W-1:0] aim,
   output logic             clear_req,
   output logic             game_active,
   output logic [7:0]       shots_fired,
   player_ctrl_if.master    fire
);

   localparam int unsigned CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   localparam logic [X_W-1:0]   X_MAX_V    = X_W'(X_MAX);
   localparam logic [X_W-1:0]   X_INIT_V   = X_W'(X_INIT);
   localparam logic [AIM_W-1:0] AIM_MAX_V  = {AIM_W{1'b1}};
   localparam logic [AIM_W-1:0] AIM_INIT_V = AIM_W'(AIM_INIT);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(COOLDOWN - 1);
   localparam logic [4:0]       SEL_NG1    = 5'b00010;
   localparam logic [4:0]       SEL_NG2    = 5'b00100;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      CLEAR,
      PLAY,
      FIRE,
      FLIGHT,
      COOLDOWN_S
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;

   logic [X_W-1:0]   player_x_d, fire_x_q, fire_x_d;
   logic [AIM_W-1:0] aim_d, fire_aim_q, fire_aim_d;
   logic             fire_valid_q, fire_valid_d;
   logic             clear_req_d, game_active_d;
   logic [7:0]       shots_d;
   logic             new_game;

   assign new_game        = (select == SEL_NG1);
   assign fire.fire_valid = fire_valid_q;
   assign fire.fire_x     = fire_x_q;
   assign fire.fire_aim   = fire_aim_q;

   // State and registered outputs; enable freezes everything, reset overrides it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         player_x     <= X_INIT_V;
         aim          <= AIM_INIT_V;
         fire_valid_q <= 1'b0;
         fire_x_q     <= '0;
         fire_aim_q   <= '0;
         clear_req    <= 1'b0;
         game_active  <= 1'b0;
         shots_fired  <= '0;
      end else if (ena) begin
         state        <= state_d;
         cnt          <= cnt_d;
         player_x     <= player_x_d;
         aim          <= aim_d;
         fire_valid_q <= fire_valid_d;
         fire_x_q     <= fire_x_d;
         fire_aim_q   <= fire_aim_d;
         clear_req    <= clear_req_d;
         game_active  <= game_active_d;
         shots_fired  <= shots_d;
      end
   end

   // Next state; a phase-1 select restarts the new-game sequence from anywhere.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      if (new_game) begin
         state_d = ARM;
      end else begin
         unique case (state)
            IDLE:       state_d = IDLE;
            ARM:        state_d = (select == SEL_NG2) ? CLEAR : IDLE;
            CLEAR:      state_d = PLAY;
            PLAY:       if (shoot_in) state_d = FIRE;
            FIRE:       if (fire_valid_q && fire.fire_ready) state_d = FLIGHT;
            FLIGHT: begin
               if (fire.shot_done) begin
                  state_d = COOLDOWN_S;
                  cnt_d   = CNT_LOAD;
               end
            end
            COOLDOWN_S: begin
               if (cnt == '0) state_d = PLAY;
               else           cnt_d   = cnt - CNT_W'(1);
            end
            default:    state_d = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs.
   always_comb begin
      player_x_d    = player_x;
      aim_d         = aim;
      fire_x_d      = fire_x_q;
      fire_aim_d    = fire_aim_q;
      shots_d       = shots_fired;
      fire_valid_d  = (state_d == FIRE);
      clear_req_d   = (state_d == CLEAR);
      game_active_d = (state_d inside {PLAY, FIRE, FLIGHT, COOLDOWN_S});

      if (!new_game) begin
         if (state == ARM && select == SEL_NG2) begin
            player_x_d = X_INIT_V;
            aim_d      = AIM_INIT_V;
            shots_d    = '0;
         end

         if (state inside {PLAY, FLIGHT, COOLDOWN_S}) begin
            if (left_x && !right_x && player_x != '0)
               player_x_d = player_x - X_W'(1);
            else if (right_x && !left_x && player_x < X_MAX_V)
               player_x_d = player_x + X_W'(1);

            if (left_aim && !right_aim && aim != '0)
               aim_d = aim - AIM_W'(1);
            else if (right_aim && !left_aim && aim != AIM_MAX_V)
               aim_d = aim + AIM_W'(1);
         end

         // Shot position is captured from the values before this cycle's move.
         if (state == PLAY && shoot_in) begin
            fire_x_d   = player_x;
            fire_aim_d = aim;
         end

         if (state == FIRE && fire_valid_q && fire.fire_ready && shots_fired != 8'hFF)
            shots_d = shots_fired + 8'd1;
      end
   end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed vector bench for player_ctrl: a table of per-cycle stimulus with
// expected outputs, followed by hand-written multi-cycle sequences.
module tb_player_ctrl;

   localparam int unsigned X_W   = 5;
   localparam int unsigned AIM_W = 3;
   localparam logic [4:0]  NONE  = 5'b00000;
   localparam logic [4:0]  NG1   = 5'b00010;
   localparam logic [4:0]  NG2   = 5'b00100;
   localparam int          NVEC  = 21;

   typedef struct packed {
      logic       ena, lx, rx, la, ra, sh;
      logic [4:0] sel;
      logic       rdy, done;
   } in_t;

   typedef struct packed {
      logic [4:0] px;
      logic [2:0] aim;
      logic       fv;
      logic [4:0] fx;
      logic [2:0] fa;
      logic       clr, act;
      logic [7:0] shots;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, ena;
   logic             left_x, right_x, left_aim, right_aim, shoot_in;
   logic [4:0]       select;
   logic [X_W-1:0]   player_x;
   logic [AIM_W-1:0] aim;
   logic             clear_req, game_active;
   logic [7:0]       shots_fired;

   int n_run  = 0;
   int n_fail = 0;

   vec_t vecs [NVEC];

   player_ctrl_if #(.X_W(X_W), .AIM_W(AIM_W)) fire_if ();

   player_ctrl #(
      .X_W(5), .X_MAX(23), .X_INIT(12), .AIM_W(3), .AIM_INIT(4), .COOLDOWN(8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ena         (ena),
      .left_x      (left_x),
      .right_x     (right_x),
      .left_aim    (left_aim),
      .right_aim   (right_aim),
      .shoot_in    (shoot_in),
      .select      (select),
      .player_x    (player_x),
      .aim         (aim),
      .clear_req   (clear_req),
      .game_active (game_active),
      .shots_fired (shots_fired),
      .fire        (fire_if)
   );

   function automatic in_t inp(int en, int lx, int rx, int la, int ra, int sh,
                               logic [4:0] sel, int rdy, int done);
      in_t r;
      r.ena  = 1'(en);
      r.lx   = 1'(lx);
      r.rx   = 1'(rx);
      r.la   = 1'(la);
      r.ra   = 1'(ra);
      r.sh   = 1'(sh);
      r.sel  = sel;
      r.rdy  = 1'(rdy);
      r.done = 1'(done);
      return r;
   endfunction

   function automatic exp_t ex(int px, int a, int fv, int fx, int fa, int clr, int act, int s);
      exp_t r;
      r.px    = 5'(px);
      r.aim   = 3'(a);
      r.fv    = 1'(fv);
      r.fx    = 5'(fx);
      r.fa    = 3'(fa);
      r.clr   = 1'(clr);
      r.act   = 1'(act);
      r.shots = 8'(s);
      return r;
   endfunction

   task automatic apply(input in_t v);
      ena                = v.ena;
      left_x             = v.lx;
      right_x            = v.rx;
      left_aim           = v.la;
      right_aim          = v.ra;
      shoot_in           = v.sh;
      select             = v.sel;
      fire_if.fire_ready = v.rdy;
      fire_if.shot_done  = v.done;
   endtask

   task automatic quiet();
      apply(inp(1, 0, 0, 0, 0, 0, NONE, 0, 0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int expv);
      n_run++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic chk_rec(input string tag, input exp_t e);
      chk({tag, ".player_x"},    int'(player_x),           int'(e.px));
      chk({tag, ".aim"},         int'(aim),                int'(e.aim));
      chk({tag, ".fire_valid"},  int'(fire_if.fire_valid), int'(e.fv));
      chk({tag, ".fire_x"},      int'(fire_if.fire_x),     int'(e.fx));
      chk({tag, ".fire_aim"},    int'(fire_if.fire_aim),   int'(e.fa));
      chk({tag, ".clear_req"},   int'(clear_req),          int'(e.clr));
      chk({tag, ".game_active"}, int'(game_active),        int'(e.act));
      chk({tag, ".shots_fired"}, int'(shots_fired),        int'(e.shots));
   endtask

   task automatic new_game();
      apply(inp(1, 0, 0, 0, 0, 0, NG1, 0, 0));  tick();
      apply(inp(1, 0, 0, 0, 0, 0, NG2, 0, 0));  tick();
      quiet();                                  tick();
   endtask

   initial begin
      //                    ena lx rx la ra sh sel   rdy done     px a  fv fx fa clr act s
      vecs[0]  = '{inp(1, 0, 0, 0, 0, 0, NG1,  0, 0), ex(12, 4, 0, 0,  0, 0, 0, 0)};
      vecs[1]  = '{inp(1, 0, 0, 0, 0, 0, NG2,  0, 0), ex(12, 4, 0, 0,  0, 1, 0, 0)};
      vecs[2]  = '{inp(1, 0, 0, 0, 0, 0, NONE, 0, 0), ex(12, 4, 0, 0,  0, 0, 1, 0)};
      vecs[3]  = '{inp(1, 0, 1, 0, 0, 0, NONE, 0, 0), ex(13, 4, 0, 0,  0, 0, 1, 0)};
      vecs[4]  = '{inp(1, 0, 0, 1, 0, 0, NONE, 0, 0), ex(13, 3, 0, 0,  0, 0, 1, 0)};
      vecs[5]  = '{inp(1, 1, 1, 0, 0, 0, NONE, 0, 0), ex(13, 3, 0, 0,  0, 0, 1, 0)};
      vecs[6]  = '{inp(1, 0, 0, 1, 1, 0, NONE, 0, 0), ex(13, 3, 0, 0,  0, 0, 1, 0)};
      vecs[7]  = '{inp(1, 0, 0, 0, 0, 1, NONE, 0, 0), ex(13, 3, 1, 13, 3, 0, 1, 0)};
      vecs[8]  = '{inp(1, 0, 1, 0, 0, 0, NONE, 0, 0), ex(13, 3, 1, 13, 3, 0, 1, 0)};
      vecs[9]  = '{inp(1, 0, 0, 0, 0, 1, NONE, 1, 0), ex(13, 3, 0, 13, 3, 0, 1, 1)};
      vecs[10] = '{inp(1, 1, 0, 0, 0, 0, NONE, 0, 0), ex(12, 3, 0, 13, 3, 0, 1, 1)};
      vecs[11] = '{inp(1, 0, 0, 0, 1, 0, NONE, 0, 1), ex(12, 4, 0, 13, 3, 0, 1, 1)};
      vecs[12] = '{inp(0, 0, 1, 0, 0, 1, NG1,  1, 1), ex(12, 4, 0, 13, 3, 0, 1, 1)};
      vecs[13] = '{inp(1, 0, 0, 0, 0, 0, NG1,  0, 0), ex(12, 4, 0, 13, 3, 0, 0, 1)};
      vecs[14] = '{inp(1, 0, 0, 0, 0, 0, NONE, 0, 0), ex(12, 4, 0, 13, 3, 0, 0, 1)};
      vecs[15] = '{inp(1, 0, 0, 0, 0, 1, NONE, 0, 0), ex(12, 4, 0, 13, 3, 0, 0, 1)};
      vecs[16] = '{inp(1, 0, 1, 0, 0, 0, NONE, 0, 0), ex(12, 4, 0, 13, 3, 0, 0, 1)};
      vecs[17] = '{inp(1, 0, 0, 0, 0, 0, NG1,  0, 0), ex(12, 4, 0, 13, 3, 0, 0, 1)};
      vecs[18] = '{inp(0, 0, 0, 0, 0, 0, NG2,  0, 0), ex(12, 4, 0, 13, 3, 0, 0, 1)};
      vecs[19] = '{inp(1, 0, 0, 0, 0, 0, NG2,  0, 0), ex(12, 4, 0, 13, 3, 1, 0, 0)};
      vecs[20] = '{inp(1, 0, 0, 0, 0, 0, NONE, 0, 0), ex(12, 4, 0, 13, 3, 0, 1, 0)};

      reset = 1'b1;
      quiet();
      tick();
      tick();
      chk_rec("reset", ex(12, 4, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;

      for (int v = 0; v < NVEC; v++) begin
         apply(vecs[v].i);
         tick();
         chk_rec($sformatf("vec%0d", v), vecs[v].e);
      end

      // Saturation of column and aim at both ends.
      for (int i = 0; i < 13; i++) begin
         apply(inp(1, 0, 1, 0, 0, 0, NONE, 0, 0));  tick();
      end
      chk("x_sat_hi", int'(player_x), 23);
      for (int i = 0; i < 5; i++) begin
         apply(inp(1, 0, 0, 1, 0, 0, NONE, 0, 0));  tick();
      end
      chk("aim_sat_lo", int'(aim), 0);
      for (int i = 0; i < 10; i++) begin
         apply(inp(1, 0, 0, 0, 1, 0, NONE, 0, 0));  tick();
      end
      chk("aim_sat_hi", int'(aim), 7);
      for (int i = 0; i < 30; i++) begin
         apply(inp(1, 1, 0, 0, 0, 0, NONE, 0, 0));  tick();
      end
      chk("x_sat_lo", int'(player_x), 0);

      // Enable low: toggling inputs must not move anything.
      for (int i = 0; i < 4; i++) begin
         apply(inp(0, (i % 2 == 0) ? 1 : 0, (i % 2 == 1) ? 1 : 0, 1, 1, 1,
                   (i == 1) ? NG1 : NG2, 1, 1));
         tick();
         chk_rec($sformatf("ena_low%0d", i), ex(0, 7, 0, 13, 3, 0, 1, 0));
      end

      // New game then shoot with a same-cycle move; stall on fire_ready.
      apply(inp(1, 0, 0, 0, 0, 0, NG1, 0, 0));  tick();
      chk("ng_arm_active", int'(game_active), 0);
      apply(inp(1, 0, 0, 0, 0, 0, NG2, 0, 0));  tick();
      chk_rec("ng_clear", ex(12, 4, 0, 13, 3, 1, 0, 0));
      quiet();                                  tick();
      chk_rec("ng_play", ex(12, 4, 0, 13, 3, 0, 1, 0));
      apply(inp(1, 0, 1, 0, 0, 1, NONE, 0, 0)); tick();
      chk_rec("shoot_move", ex(13, 4, 1, 12, 4, 0, 1, 0));
      for (int i = 0; i < 5; i++) begin
         apply(inp(1, 1, 0, 1, 0, 0, NONE, 0, 0));  tick();
         chk($sformatf("stall_fv%0d", i), int'(fire_if.fire_valid), 1);
         chk($sformatf("stall_fx%0d", i), int'(fire_if.fire_x), 12);
      end
      chk("stall_no_move", int'(player_x), 13);
      apply(inp(1, 0, 0, 0, 0, 0, NONE, 1, 0)); tick();
      chk("hs_fv", int'(fire_if.fire_valid), 0);
      chk("hs_shots", int'(shots_fired), 1);
      apply(inp(1, 0, 0, 0, 0, 0, NONE, 1, 0)); tick();
      chk("ready_no_valid", int'(shots_fired), 1);

      // Cooldown: shots during it are dropped; PLAY 9 cycles after shot_done.
      apply(inp(1, 0, 0, 0, 0, 0, NONE, 0, 1)); tick();
      for (int i = 1; i <= 9; i++) begin
         apply(inp(1, 0, 0, 0, 0, (i == 3 || i == 8 || i == 9) ? 1 : 0, NONE, 0, 0));
         tick();
         chk($sformatf("cooldown_fv%0d", i), int'(fire_if.fire_valid), (i == 9) ? 1 : 0);
      end
      chk_rec("refire", ex(13, 4, 1, 13, 4, 0, 1, 1));

      // New game while a shot is pending.
      apply(inp(1, 0, 0, 0, 0, 0, NG1, 0, 0));  tick();
      chk("ng_fire_fv", int'(fire_if.fire_valid), 0);
      chk("ng_fire_act", int'(game_active), 0);
      apply(inp(1, 0, 0, 0, 0, 0, NG2, 0, 0));  tick();
      chk_rec("ng_fire_clear", ex(12, 4, 0, 13, 4, 1, 0, 0));
      quiet();                                  tick();
      chk("ng_fire_play", int'(game_active), 1);

      // Reset mid-FIRE with enable low, then reset mid-FLIGHT.
      apply(inp(1, 0, 0, 0, 0, 1, NONE, 0, 0)); tick();
      chk("pre_reset_fv", int'(fire_if.fire_valid), 1);
      apply(inp(0, 0, 0, 0, 0, 0, NONE, 0, 0));
      reset = 1'b1;  tick();  reset = 1'b0;
      chk_rec("reset_fire", ex(12, 4, 0, 0, 0, 0, 0, 0));
      new_game();
      apply(inp(1, 0, 0, 0, 0, 1, NONE, 0, 0)); tick();
      apply(inp(1, 0, 0, 0, 0, 0, NONE, 1, 0)); tick();
      apply(inp(1, 0, 1, 0, 1, 0, NONE, 0, 0)); tick();
      chk_rec("flight", ex(13, 5, 0, 12, 4, 0, 1, 1));
      quiet();
      reset = 1'b1;  tick();  reset = 1'b0;
      chk_rec("reset_flight", ex(12, 4, 0, 0, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
